// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle arithmetic/logic ops plus iterative normalise,
// restoring divide and nibble-pattern count behind a start/busy/done handshake.
module alu_mc #(
  parameter int W  = 8,
  parameter int PW = 4,
  parameter int CW = $clog2(W+1)
) (
  input  logic          CLK,
  input  logic          reset,
  input  logic          start,
  input  logic [3:0]    OP,
  input  logic          CI,
  input  logic [W-1:0]  INPUTA,
  input  logic [W-1:0]  INPUTB,
  input  logic [PW-1:0] INPUTD,
  output logic          busy,
  output logic          done,
  output logic [W-1:0]  OUT,
  output logic [W-1:0]  OUT2,
  output logic          CO,
  output logic          ZERO
);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_t;

  localparam logic [CW-1:0] CNT_W = CW'(W);
  localparam logic [CW-1:0] SEQ_N = CW'(W-PW+1);

  state_t        state_q, state_d;
  logic [3:0]    op_q, op_d;
  logic          ci_q, ci_d;
  logic [W-1:0]  a_q, a_d, b_q, b_d, r_q, r_d, q_q, q_d;
  logic [PW-1:0] d_q, d_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  out_q, out_d, out2_q, out2_d;
  logic          co_q, co_d, zero_q, zero_d;

  logic          fin;
  logic [W-1:0]  res_out, res_out2;
  logic          res_co;
  logic [W:0]    sum, r_sh, r_sub;

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    ci_d     = ci_q;
    a_d      = a_q;
    b_d      = b_q;
    d_d      = d_q;
    r_d      = r_q;
    q_d      = q_q;
    cnt_d    = cnt_q;
    out_d    = out_q;
    out2_d   = out2_q;
    co_d     = co_q;
    zero_d   = zero_q;
    fin      = 1'b0;
    res_out  = '0;
    res_out2 = '0;
    res_co   = 1'b0;
    sum      = '0;
    r_sh     = {r_q, a_q[W-1]};
    r_sub    = r_sh - {1'b0, b_q};
    case (state_q)
      S_IDLE: if (start) begin
        op_d    = OP;
        ci_d    = CI;
        a_d     = INPUTA;
        b_d     = INPUTB;
        d_d     = INPUTD;
        r_d     = '0;
        q_d     = '0;
        cnt_d   = '0;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        case (op_q)
          4'd0: begin
            sum = {1'b0, a_q} + {1'b0, b_q} + {{W{1'b0}}, ci_q};
            fin = 1'b1; res_out = sum[W-1:0]; res_co = sum[W];
          end
          4'd1: begin
            sum = {1'b0, a_q} + {1'b0, ~b_q} + {{W{1'b0}}, ci_q};
            fin = 1'b1; res_out = sum[W-1:0]; res_co = sum[W];
          end
          4'd2: begin fin = 1'b1; res_out = {a_q[W-2:0], 1'b0}; res_co = a_q[W-1]; end
          4'd3: begin fin = 1'b1; res_out = {1'b0, a_q[W-1:1]}; res_co = a_q[0]; end
          4'd4: begin fin = 1'b1; res_out = {a_q[W-1], a_q[W-1:1]}; res_co = a_q[0]; end
          4'd5: begin fin = 1'b1; res_out = {{(W-1){1'b0}}, a_q > b_q}; end
          4'd6: begin fin = 1'b1; res_out = {{(W-1){1'b0}}, a_q < b_q}; end
          4'd7: begin fin = 1'b1; res_out = '0 - a_q; res_co = |a_q; end
          4'd8: begin
            // a zero operand runs the full W shifts, which is how CO=1 falls out
            if (a_q[W-1] || cnt_q == CNT_W) begin
              fin = 1'b1; res_out = a_q; res_out2 = W'(cnt_q); res_co = (cnt_q == CNT_W);
            end else begin
              a_d = {a_q[W-2:0], 1'b0}; cnt_d = cnt_q + CW'(1);
            end
          end
          4'd9: begin
            if (b_q == '0) begin
              fin = 1'b1; res_out = '1; res_out2 = a_q; res_co = 1'b1;
            end else if (cnt_q == CNT_W) begin
              fin = 1'b1; res_out = q_q; res_out2 = r_q;
            end else begin
              // dividend shifts out of a_q MSB-first into the partial remainder
              if (r_sh >= {1'b0, b_q}) begin
                r_d = r_sub[W-1:0]; q_d = {q_q[W-2:0], 1'b1};
              end else begin
                r_d = r_sh[W-1:0];  q_d = {q_q[W-2:0], 1'b0};
              end
              a_d = {a_q[W-2:0], 1'b0}; cnt_d = cnt_q + CW'(1);
            end
          end
          4'd10: begin
            // top PW bits of the left-shifting copy walk windows i=W-PW..0
            if (cnt_q == SEQ_N) begin
              fin = 1'b1; res_out = q_q; res_co = |q_q;
            end else begin
              if (a_q[W-1 -: PW] == d_q) q_d = q_q + W'(1);
              a_d = {a_q[W-2:0], 1'b0}; cnt_d = cnt_q + CW'(1);
            end
          end
          default: begin fin = 1'b1; res_co = 1'b1; end
        endcase
        if (fin) begin
          out_d   = res_out;
          out2_d  = res_out2;
          co_d    = res_co;
          zero_d  = (res_out == '0);
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      ci_q    <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      d_q     <= '0;
      r_q     <= '0;
      q_q     <= '0;
      cnt_q   <= '0;
      out_q   <= '0;
      out2_q  <= '0;
      co_q    <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      ci_q    <= ci_d;
      a_q     <= a_d;
      b_q     <= b_d;
      d_q     <= d_d;
      r_q     <= r_d;
      q_q     <= q_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      out2_q  <= out2_d;
      co_q    <= co_d;
      zero_q  <= zero_d;
    end
  end

  assign busy = (state_q == S_EXEC);
  assign done = (state_q == S_DONE);
  assign OUT  = out_q;
  assign OUT2 = out2_q;
  assign CO   = co_q;
  assign ZERO = zero_q;

endmodule
